bus_cycle_ctrl: RTL and testbench
=================================

BUS_CYCLE_CTRL -- requirements
Module: bus_cycle_ctrl

Interface
REQ-001 SHALL have parameter E_LOW: default 6; E-clock low-phase length in i_CLK cycles.
REQ-002 SHALL have parameter E_HIGH: default 4; E-clock high-phase length in i_CLK cycles.
REQ-003 SHALL have parameter FAST_WAIT: default 2, legal range 0..15; wait states for fast-device cycles.
REQ-004 SHALL have parameter BERR_CYCLES: default 64, legal range 2..255; no-response timeout in i_CLK cycles.
REQ-005 SHALL have port i_CLK, input, 1 bit; system clock, all logic on the rising edge.
REQ-006 SHALL have port i_RESET_n, input, 1 bit; synchronous, active-low reset.
REQ-007 SHALL have port i_AS_n, input, 1 bit; CPU address strobe, active-low, already synchronous to i_CLK.
REQ-008 SHALL have port i_SEL_FAST, input, 1 bit; decoder hit on a fast device (RAM/ROM/UART).
REQ-009 SHALL have port i_SEL_SLOW, input, 1 bit; decoder hit on a 6800-style peripheral.
REQ-010 SHALL have port o_E, output, 1 bit; free-running E clock.
REQ-011 SHALL have port o_VMA_n, output, 1 bit; valid-memory-address strobe for slow peripherals, active-low.
REQ-012 SHALL have port o_DTACK_n, output, 1 bit; data transfer acknowledge to the CPU, active-low.
REQ-013 SHALL have port o_BERR_n, output, 1 bit; bus error to the CPU, active-low.
REQ-014 SHALL have port o_BUSY, output, 1 bit; high whenever the FSM is not in IDLE.

Function
REQ-015 E generator SHALL count 0..E_LOW+E_HIGH-1 and wrap to 0.
- o_E low for counts 0..E_LOW-1, high for the remaining counts; registered output.
REQ-016 FSM SHALL have states IDLE, FAST, SLOW_SYNC, SLOW_ACT, ACK, FAULT.
REQ-017 IDLE SHALL decode on the first cycle i_AS_n is sampled low:
- i_SEL_FAST -> FAST (fast has priority when both selects are high);
- else i_SEL_SLOW -> SLOW_SYNC;
- else -> FAULT.
REQ-018 FAST SHALL count FAST_WAIT cycles, then go to ACK.
- o_DTACK_n SHALL be low exactly FAST_WAIT+1 cycles after i_AS_n is first sampled low.
REQ-019 SLOW_SYNC SHALL wait until the E count equals 0, then go to SLOW_ACT and drive o_VMA_n low in that same cycle.
- If entry occurs on count 0, the FSM waits for the next count 0.
REQ-020 SLOW_ACT SHALL hold o_VMA_n low through the E-high phase.
- On E count E_LOW+E_HIGH-2, the FSM goes to ACK, so o_DTACK_n is low during the last E-high cycle.
REQ-021 ACK SHALL hold o_DTACK_n (and o_VMA_n, for slow cycles) low until i_AS_n is sampled high, then return to IDLE.
- All strobes SHALL be high in the cycle after that.
REQ-022 FAULT SHALL drive o_BERR_n low until i_AS_n is sampled high, then return to IDLE.
REQ-023 i_AS_n rising in FAST, SLOW_SYNC or SLOW_ACT (aborted cycle) SHALL:
- return the FSM to IDLE on the next edge;
- not assert o_DTACK_n;
- deassert o_VMA_n.
REQ-024 o_DTACK_n and o_BERR_n SHALL never be low in the same cycle.
REQ-025 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-026 While i_RESET_n is low at a clock edge, the block SHALL reset to these values:
- FSM = IDLE;
- E count = 0;
- o_E = 0;
- o_VMA_n = 1;
- o_DTACK_n = 1;
- o_BERR_n = 1;
- o_BUSY = 0.
REQ-027 Reset asserted mid-cycle SHALL abort the cycle with no acknowledge.
- The E count restarts at 0 after reset release.

Configuration
REQ-028 With macro BUS_CYCLE_CTRL_TIMEOUT_EN defined, a watchdog SHALL count cycles in FAST, SLOW_SYNC and SLOW_ACT.
- On reaching BERR_CYCLES, the FSM SHALL enter FAULT.
- The watchdog SHALL clear on IDLE.
REQ-029 Without the macro, no watchdog logic SHALL be synthesised.
- Unselected accesses still go to FAULT per REQ-017.

Structure
REQ-030 Shared package bus_cycle_pkg SHALL hold:
- FSM state enum;
- default timing constants (E_LOW, E_HIGH, FAST_WAIT, BERR_CYCLES).
REQ-031 The E counter and o_E SHALL live in sub-module e_clock_gen.
- It exports the count value and a one-cycle "count==0" strobe consumed by the FSM.

Verification
REQ-032 Reset: hold i_RESET_n low 3 cycles -> all outputs at REQ-026 values; o_E first rises 6 cycles after release.
REQ-033 Fast read, FAST_WAIT=2: i_AS_n low with i_SEL_FAST=1 at cycle T -> o_DTACK_n low at T+3; high one cycle after i_AS_n is sampled high.
REQ-034 Slow read entering at E count 3 -> o_VMA_n low at next count 0; o_DTACK_n low at count 9; o_E high at counts 6..9.
REQ-035 No select: i_AS_n low, both selects 0 -> o_BERR_n low next cycle, o_DTACK_n stays high; release on i_AS_n high.
REQ-036 Abort: i_AS_n high during SLOW_SYNC -> o_DTACK_n never asserted, o_BUSY=0 next cycle.
REQ-037 TIMEOUT_EN with BERR_CYCLES=8 and E_LOW forced to 20 -> o_BERR_n low 8 cycles after entering SLOW_SYNC.

Source files
------------

// File: rtl/bus_cycle_pkg.sv
// Shared types and default timing for the 68000-style bus cycle controller.
package bus_cycle_pkg;

  localparam int DEF_E_LOW       = 6;
  localparam int DEF_E_HIGH      = 4;
  localparam int DEF_FAST_WAIT   = 2;
  localparam int DEF_BERR_CYCLES = 64;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FAST      = 3'd1,
    SLOW_SYNC = 3'd2,
    SLOW_ACT  = 3'd3,
    ACK       = 3'd4,
    FAULT     = 3'd5
  } bus_state_t;

  // States in which a cycle is still waiting for its device to respond.
  function automatic logic in_access(bus_state_t s);
    return (s == FAST) || (s == SLOW_SYNC) || (s == SLOW_ACT);
  endfunction

endpackage

// File: rtl/e_clock_gen.sv
// Free-running 6800-style E clock: counter 0..E_LOW+E_HIGH-1, E high for the
// last E_HIGH counts. Exports the count and a strobe for the final count.
module e_clock_gen #(
  parameter int E_LOW  = 6,
  parameter int E_HIGH = 4,
  parameter int CW     = 4
) (
  input  logic          i_CLK,
  input  logic          i_RESET_n,
  output logic [CW-1:0] count,
  output logic          e,
  output logic          wrap
);

  localparam logic [CW-1:0] LAST       = CW'(E_LOW + E_HIGH - 1);
  localparam logic [CW-1:0] HIGH_START = CW'(E_LOW);

  logic [CW-1:0] count_next;

  // wrap is high in the last count, so the count is 0 after the next edge;
  // this lets registered strobes line up exactly with count 0.
  assign wrap       = (count == LAST);
  assign count_next = wrap ? '0 : count + CW'(1);

  always_ff @(posedge i_CLK) begin
    if (!i_RESET_n) begin
      count <= '0;
      e     <= 1'b0;
    end else begin
      count <= count_next;
      e     <= (count_next >= HIGH_START);
    end
  end

endmodule

// File: rtl/bus_cycle_ctrl.sv
// 68000 bus cycle controller: DTACK/BERR generation for fast devices and
// E-clock-synchronous VMA cycles for 6800 peripherals.
// Optional no-response watchdog: define BUS_CYCLE_CTRL_TIMEOUT_EN.
//
// Handshake: a cycle starts on the first edge that samples i_AS_n low in IDLE;
// the CPU ends it by raising i_AS_n, which always returns the FSM to IDLE on
// the next edge with every strobe released in the following cycle.
module bus_cycle_ctrl
  import bus_cycle_pkg::*;
#(
  parameter int E_LOW       = DEF_E_LOW,
  parameter int E_HIGH      = DEF_E_HIGH,
  parameter int FAST_WAIT   = DEF_FAST_WAIT,
  parameter int BERR_CYCLES = DEF_BERR_CYCLES
) (
  input  logic       i_CLK,
  input  logic       i_RESET_n,
  input  logic       i_AS_n,
  input  logic       i_SEL_FAST,
  input  logic       i_SEL_SLOW,
  output logic       o_E,
  output logic       o_VMA_n,
  output logic       o_DTACK_n,
  output logic       o_BERR_n,
  output logic       o_BUSY,
  output bus_state_t dbg_state
);

  localparam int            E_N       = E_LOW + E_HIGH;
  localparam int            CW        = (E_N > 2) ? $clog2(E_N) : 1;
  localparam logic [CW-1:0] ACK_COUNT = CW'(E_N - 2);

  bus_state_t    state_q, state_next;
  logic [3:0]    wcnt_q, wcnt_next;
  logic [CW-1:0] e_count;
  logic          e_wrap;
  logic          timeout;
  logic          vma_n_next, dtack_n_next, berr_n_next, busy_next;

  e_clock_gen #(
    .E_LOW  (E_LOW),
    .E_HIGH (E_HIGH),
    .CW     (CW)
  ) u_e_clock_gen (
    .i_CLK     (i_CLK),
    .i_RESET_n (i_RESET_n),
    .count     (e_count),
    .e         (o_E),
    .wrap      (e_wrap)
  );

`ifdef BUS_CYCLE_CTRL_TIMEOUT_EN
  logic [7:0] wd_q;

  always_ff @(posedge i_CLK) begin
    if (!i_RESET_n || !in_access(state_q) || !in_access(state_next)) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_q + 8'd1;
    end
  end

  assign timeout = (wd_q == 8'(BERR_CYCLES - 1));
`else
  // BERR_CYCLES is never 0 in its legal range, so this ties timeout low.
  assign timeout = (BERR_CYCLES == 0);
`endif

  always_comb begin
    state_next = state_q;
    wcnt_next  = '0;
    case (state_q)
      IDLE: begin
        if (!i_AS_n) begin
          if (i_SEL_FAST)      state_next = FAST;
          else if (i_SEL_SLOW) state_next = SLOW_SYNC;
          else                 state_next = FAULT;
        end
      end
      FAST: begin
        if (i_AS_n)                       state_next = IDLE;
        else if (timeout)                 state_next = FAULT;
        else if (wcnt_q == 4'(FAST_WAIT)) state_next = ACK;
        else                              wcnt_next  = wcnt_q + 4'd1;
      end
      SLOW_SYNC: begin
        if (i_AS_n)       state_next = IDLE;
        else if (timeout) state_next = FAULT;
        else if (e_wrap)  state_next = SLOW_ACT;
      end
      SLOW_ACT: begin
        if (i_AS_n)                    state_next = IDLE;
        else if (timeout)              state_next = FAULT;
        else if (e_count == ACK_COUNT) state_next = ACK;
      end
      ACK, FAULT: begin
        if (i_AS_n) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // Strobes are registered from the next state so they change on the edge
    // that enters a state, never combinationally from the inputs.
    dtack_n_next = (state_next != ACK);
    berr_n_next  = (state_next != FAULT);
    busy_next    = (state_next != IDLE);
    vma_n_next   = 1'b1;
    if (state_next == SLOW_ACT) begin
      vma_n_next = 1'b0;
    end else if (state_next == ACK) begin
      // VMA stays low through ACK only when the cycle arrived via SLOW_ACT.
      if (state_q == SLOW_ACT)  vma_n_next = 1'b0;
      else if (state_q == ACK)  vma_n_next = o_VMA_n;
    end
  end

  always_ff @(posedge i_CLK) begin
    if (!i_RESET_n) begin
      state_q   <= IDLE;
      wcnt_q    <= '0;
      o_VMA_n   <= 1'b1;
      o_DTACK_n <= 1'b1;
      o_BERR_n  <= 1'b1;
      o_BUSY    <= 1'b0;
    end else begin
      state_q   <= state_next;
      wcnt_q    <= wcnt_next;
      o_VMA_n   <= vma_n_next;
      o_DTACK_n <= dtack_n_next;
      o_BERR_n  <= berr_n_next;
      o_BUSY    <= busy_next;
    end
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Directed bench for bus_cycle_ctrl: per-cycle vector table plus hand-written
// slow-cycle, abort, reset and (with BUS_CYCLE_CTRL_TIMEOUT_EN) watchdog sequences.
module tb_bus_cycle_ctrl;
  import bus_cycle_pkg::*;

  localparam int E_N = 10;

  logic       clk = 1'b0;
  logic       rst_n, as_n, sel_fast, sel_slow;
  logic       e, vma_n, dtack_n, berr_n, busy;
  bus_state_t dbg_state;

  int checks = 0;
  int errors = 0;
  int ecnt   = 0;

  typedef struct {
    string name;
    logic  as_n, sel_fast, sel_slow;
    logic  vma_n, dtack_n, berr_n, busy;
  } vec_t;

  vec_t vecs[18];

  always #5 clk = ~clk;

  bus_cycle_ctrl u_dut (
    .i_CLK      (clk),
    .i_RESET_n  (rst_n),
    .i_AS_n     (as_n),
    .i_SEL_FAST (sel_fast),
    .i_SEL_SLOW (sel_slow),
    .o_E        (e),
    .o_VMA_n    (vma_n),
    .o_DTACK_n  (dtack_n),
    .o_BERR_n   (berr_n),
    .o_BUSY     (busy),
    .dbg_state  (dbg_state)
  );

`ifdef BUS_CYCLE_CTRL_TIMEOUT_EN
  logic       as2_n, sel_slow2;
  logic       e2, vma2_n, dtack2_n, berr2_n, busy2;
  bus_state_t dbg_state2;

  bus_cycle_ctrl #(.E_LOW(20), .BERR_CYCLES(8)) u_wd (
    .i_CLK      (clk),
    .i_RESET_n  (rst_n),
    .i_AS_n     (as2_n),
    .i_SEL_FAST (1'b0),
    .i_SEL_SLOW (sel_slow2),
    .o_E        (e2),
    .o_VMA_n    (vma2_n),
    .o_DTACK_n  (dtack2_n),
    .o_BERR_n   (berr2_n),
    .o_BUSY     (busy2),
    .dbg_state  (dbg_state2)
  );
`endif

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at t=%0t (ecnt=%0d)", name, act, exp, $time, ecnt);
    end
  endtask

  // One clock: update the E-count model, then check E and DTACK/BERR exclusion.
  task automatic tick();
    @(posedge clk);
    ecnt = !rst_n ? 0 : ((ecnt == E_N - 1) ? 0 : ecnt + 1);
    #1;
    chk("o_E", e, (ecnt >= 6) ? 1'b1 : 1'b0);
    chk("dtack_berr_excl", dtack_n | berr_n, 1'b1);
  endtask

  task automatic outs(input string name, input logic x_vma_n, input logic x_dtack_n,
                      input logic x_berr_n, input logic x_busy);
    chk({name, ".vma_n"},   vma_n,   x_vma_n);
    chk({name, ".dtack_n"}, dtack_n, x_dtack_n);
    chk({name, ".berr_n"},  berr_n,  x_berr_n);
    chk({name, ".busy"},    busy,    x_busy);
  endtask

  task automatic idle_until(input int c);
    as_n = 1'b1; sel_fast = 1'b0; sel_slow = 1'b0;
    for (int n = 0; n < E_N && ecnt != c; n++) tick();
  endtask

  // Slow read whose decode edge lands on E count `entry`.
  task automatic slow_read(input int entry);
    int z;
    idle_until((entry + E_N - 1) % E_N);
    as_n = 1'b0; sel_slow = 1'b1;
    tick();
    outs("slow_entry", 1'b1, 1'b1, 1'b1, 1'b1);
    z = (entry == 0) ? E_N : E_N - entry;
    for (int n = 1; n <= z; n++) begin
      tick();
      if (n == z) outs("slow_vma_on", 1'b0, 1'b1, 1'b1, 1'b1);
      else        outs("slow_sync",   1'b1, 1'b1, 1'b1, 1'b1);
    end
    for (int n = 1; n < E_N; n++) begin
      tick();
      outs("slow_act", 1'b0, (ecnt == E_N - 1) ? 1'b0 : 1'b1, 1'b1, 1'b1);
    end
    tick();
    outs("slow_ack_hold", 1'b0, 1'b0, 1'b1, 1'b1);
    as_n = 1'b1; sel_slow = 1'b0;
    tick();
    outs("slow_release", 1'b1, 1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL sim_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{"idle",       1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[1]  = '{"fast_dec",   1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[2]  = '{"fast_w1",    1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[3]  = '{"fast_w2",    1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[4]  = '{"fast_ack",   1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[5]  = '{"fast_hold",  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[6]  = '{"fast_rel",   1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{"nosel_berr", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{"nosel_hold", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{"nosel_rel",  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{"both_dec",   1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[11] = '{"both_w1",    1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[12] = '{"both_w2",    1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[13] = '{"both_ack",   1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[14] = '{"both_rel",   1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[15] = '{"fabort_dec", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[16] = '{"fabort",     1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[17] = '{"idle2",      1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    // Clock/reset: three cycles of reset, then check reset values.
    rst_n = 1'b0; as_n = 1'b1; sel_fast = 1'b0; sel_slow = 1'b0;
`ifdef BUS_CYCLE_CTRL_TIMEOUT_EN
    as2_n = 1'b1; sel_slow2 = 1'b0;
`endif
    repeat (3) tick();
    outs("reset", 1'b1, 1'b1, 1'b1, 1'b0);
    rst_n = 1'b1;

    // Cycle-by-cycle vectors from reset release; E checked in every tick.
    for (int i = 0; i < 18; i++) begin
      as_n = vecs[i].as_n; sel_fast = vecs[i].sel_fast; sel_slow = vecs[i].sel_slow;
      tick();
      outs(vecs[i].name, vecs[i].vma_n, vecs[i].dtack_n, vecs[i].berr_n, vecs[i].busy);
    end

    // Slow reads entering mid-period, on count 0 and on the last count.
    slow_read(3);
    slow_read(0);
    slow_read(9);

    // Abort during SLOW_SYNC.
    idle_until(3);
    as_n = 1'b0; sel_slow = 1'b1;
    tick();
    outs("sabort_entry", 1'b1, 1'b1, 1'b1, 1'b1);
    as_n = 1'b1; sel_slow = 1'b0;
    tick();
    outs("sabort_sync", 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    outs("sabort_idle", 1'b1, 1'b1, 1'b1, 1'b0);

    // Abort during SLOW_ACT: VMA released, no DTACK.
    idle_until(8);
    as_n = 1'b0; sel_slow = 1'b1;
    tick();
    tick();
    outs("aabort_vma", 1'b0, 1'b1, 1'b1, 1'b1);
    tick();
    as_n = 1'b1; sel_slow = 1'b0;
    tick();
    outs("aabort_act", 1'b1, 1'b1, 1'b1, 1'b0);

    // Reset mid fast cycle: no acknowledge, E restarts from 0.
    as_n = 1'b0; sel_fast = 1'b1;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    outs("midreset", 1'b1, 1'b1, 1'b1, 1'b0);
    rst_n = 1'b1; as_n = 1'b1; sel_fast = 1'b0;
    for (int n = 0; n < 7; n++) begin
      tick();
      outs("post_reset", 1'b1, 1'b1, 1'b1, 1'b0);
    end

`ifdef BUS_CYCLE_CTRL_TIMEOUT_EN
    // Watchdog: BERR 8 cycles after entering SLOW_SYNC.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; as2_n = 1'b0; sel_slow2 = 1'b1;
    tick();
    chk("wd_entry.busy", busy2, 1'b1);
    for (int n = 1; n <= 8; n++) begin
      tick();
      chk("wd.berr_n", berr2_n, (n == 8) ? 1'b0 : 1'b1);
      chk("wd.dtack_n", dtack2_n, 1'b1);
    end
    as2_n = 1'b1; sel_slow2 = 1'b0;
    tick();
    chk("wd_rel.berr_n", berr2_n, 1'b1);
    chk("wd_rel.busy", busy2, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
